// File: rtl/write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// write_buffer_pkg
//
// Shared constants and types for the cache write buffer.
//   WB_DEPTH        default number of buffered cachelines
//   ADDR_WIDTH      default byte address width
//   CACHELINE_WIDTH default cacheline width in bits
//   OFFSET_WIDTH    default number of line-offset bits ignored in compares
//   wb_state_e      drain FSM states (WB_IDLE, WB_REQ)
// -----------------------------------------------------------------------------
package write_buffer_pkg;

    localparam int WB_DEPTH        = 4;
    localparam int ADDR_WIDTH      = 32;
    localparam int CACHELINE_WIDTH = 128;
    localparam int OFFSET_WIDTH    = 4;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/write_buffer_drain_ctrl.sv
// -----------------------------------------------------------------------------
// wb_drain_ctrl
//
// Drain side of the write buffer: owns the read pointer, the two-state drain
// FSM and the registered main-memory write port.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   count          registered number of valid entries in the buffer
//   push_alloc     a new entry is being allocated this cycle
//   mem_wr_ack     memory accepted the request currently presented
//   load_addr/data contents of entry rd_ptr_next as they will be after this
//                  edge (includes any write landing in the same cycle)
//   rd_ptr         current read pointer (entry under drain when requesting)
//   rd_ptr_next    read pointer after this edge
//   pop            current entry retires this cycle
//   mem_wr_*       registered memory write request, address and data
// -----------------------------------------------------------------------------
module wb_drain_ctrl #(
    parameter int DEPTH      = write_buffer_pkg::WB_DEPTH,
    parameter int ADDR_WIDTH = write_buffer_pkg::ADDR_WIDTH,
    parameter int LINE_WIDTH = write_buffer_pkg::CACHELINE_WIDTH,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_W-1:0]      count,
    input  logic                  push_alloc,
    input  logic                  mem_wr_ack,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [LINE_WIDTH-1:0] load_data,
    output logic [PTR_W-1:0]      rd_ptr,
    output logic [PTR_W-1:0]      rd_ptr_next,
    output logic                  pop,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [LINE_WIDTH-1:0] mem_wr_data
);
    import write_buffer_pkg::*;

    wb_state_e             state_q, state_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;
    logic                  load_en;

    // Control decisions only. In REQ the buffer holds at least one entry, so
    // the post-pop count is nonzero unless this was the last entry and
    // nothing new is arriving; deciding from count/push_alloc avoids a
    // dependency on the count update that itself depends on pop.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        req_d    = req_q;
        pop      = 1'b0;
        load_en  = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (count != '0) begin
                    state_d = WB_REQ;
                    req_d   = 1'b1;
                    load_en = 1'b1;
                end
            end
            WB_REQ: begin
                if (mem_wr_ack) begin
                    pop      = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (count != CNT_W'(1) || push_alloc) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = WB_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = WB_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Memory port payload; kept separate so the entry mux in the top, which
    // is indexed by rd_ptr_next, does not form a loop with the control block.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (load_en) begin
            addr_d = load_addr;
            data_d = load_data;
        end
    end

    // FSM state, read pointer and registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WB_IDLE;
            rd_ptr_q <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign rd_ptr      = rd_ptr_q;
    assign rd_ptr_next = rd_ptr_d;
    assign mem_wr_req  = req_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;

endmodule

// File: rtl/write_buffer.sv
// -----------------------------------------------------------------------------
// write_buffer
//
// FIFO of dirty cachelines evicted by the cache data RAM, drained one line per
// handshake to main memory, with combinational read-forwarding for refills.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   write_buffer_en         push request; addr/data_to_write_buffer carry the line
//   wb_full/wb_empty        registered-count status; wb_count = valid entries
//   mem_wr_req/addr/data    memory write request (address offset bits zeroed)
//   mem_wr_ack              memory accepted the current write
//   lookup_addr             refill address; lookup_hit/lookup_data return the
//                           youngest buffered copy of that line (data 0 on miss)
//
// Build option: define WB_COALESCE_EN to merge a push into an existing
// buffered copy of the same line (except the one currently being drained).
// -----------------------------------------------------------------------------
module write_buffer #(
    parameter int DEPTH        = write_buffer_pkg::WB_DEPTH,
    parameter int ADDR_WIDTH   = write_buffer_pkg::ADDR_WIDTH,
    parameter int LINE_WIDTH   = write_buffer_pkg::CACHELINE_WIDTH,
    parameter int OFFSET_WIDTH = write_buffer_pkg::OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    write_buffer_en,
    input  logic [ADDR_WIDTH-1:0]   addr_to_write_buffer,
    input  logic [LINE_WIDTH-1:0]   data_to_write_buffer,
    output logic                    wb_full,
    output logic                    wb_empty,
    output logic [$clog2(DEPTH):0]  wb_count,
    output logic                    mem_wr_req,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [LINE_WIDTH-1:0]   mem_wr_data,
    input  logic                    mem_wr_ack,
    input  logic [ADDR_WIDTH-1:0]   lookup_addr,
    output logic                    lookup_hit,
    output logic [LINE_WIDTH-1:0]   lookup_data
);
    import write_buffer_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_WIDTH;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [LINE_WIDTH-1:0] data_q [DEPTH];
    logic [LINE_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [ADDR_WIDTH-1:0] push_line;
    logic                  push_alloc;
    logic                  coalesce_hit;
    logic [PTR_W-1:0]      coalesce_idx;
    logic                  pop;
    logic [PTR_W-1:0]      rd_ptr, rd_ptr_next;

    assign push_line = addr_to_write_buffer & LINE_MASK;
    assign wb_full   = (count_q == CNT_W'(DEPTH));
    assign wb_empty  = (count_q == '0);
    assign wb_count  = count_q;

`ifdef WB_COALESCE_EN
    // A push may merge into a buffered copy of the same line, but never into
    // the line already latched onto the memory port; that case allocates.
    always_comb begin
        coalesce_hit = 1'b0;
        coalesce_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (write_buffer_en && valid_q[i] && addr_q[i] == push_line &&
                !(mem_wr_req && rd_ptr == PTR_W'(i))) begin
                coalesce_hit = 1'b1;
                coalesce_idx = PTR_W'(i);
            end
        end
    end
`else
    assign coalesce_hit = 1'b0;
    assign coalesce_idx = '0;
`endif

    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for a push.
    assign push_alloc = write_buffer_en && !wb_full && !coalesce_hit;

    // Next contents of the line array. The drain side loads from these
    // next-state values so a same-cycle write is never missed.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (push_alloc) begin
            addr_d[wr_ptr_q] = push_line;
            data_d[wr_ptr_q] = data_to_write_buffer;
        end
        if (coalesce_hit) begin
            data_d[coalesce_idx] = data_to_write_buffer;
        end
    end

    // Valid bits, write pointer and occupancy.
    always_comb begin
        valid_d = valid_q;
        if (pop) begin
            valid_d[rd_ptr] = 1'b0;
        end
        if (push_alloc) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_alloc);
        count_d  = count_q + CNT_W'(push_alloc) - CNT_W'(pop);
    end

    // Forwarding: walk entries oldest to youngest from rd_ptr so the last
    // match seen is the youngest copy of the line.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (valid_q[idx] && addr_q[idx] == (lookup_addr & LINE_MASK)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end

    // Line storage and push-side state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    wb_drain_ctrl #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_drain_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .count       (count_q),
        .push_alloc  (push_alloc),
        .mem_wr_ack  (mem_wr_ack),
        .load_addr   (addr_d[rd_ptr_next]),
        .load_data   (data_d[rd_ptr_next]),
        .rd_ptr      (rd_ptr),
        .rd_ptr_next (rd_ptr_next),
        .pop         (pop),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

endmodule

// File: tb/tb_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_write_buffer
//
// Self-checking bench for write_buffer. A queue-based model of the buffer
// (oldest entry at the front, current memory request held separately) is
// advanced on every clock edge and compared against the DUT on every falling
// edge. Directed sequences pin the model with literal expectations, then a
// randomized phase exercises pushes, acks and lookups over a small address
// pool. Honours WB_COALESCE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int LW    = 128;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] LINE_MASK = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          write_buffer_en = 1'b0;
    logic [AW-1:0] addr_to_write_buffer = '0;
    logic [LW-1:0] data_to_write_buffer = '0;
    logic          wb_full;
    logic          wb_empty;
    logic [CW-1:0] wb_count;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [LW-1:0] mem_wr_data;
    logic          mem_wr_ack = 1'b0;
    logic [AW-1:0] lookup_addr = '0;
    logic          lookup_hit;
    logic [LW-1:0] lookup_data;

    int   total = 0;
    int   bad = 0;
    ent_t mq[$];
    logic m_req = 1'b0;
    ent_t m_cur = '0;

    always #5 clk = ~clk;

    write_buffer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .write_buffer_en      (write_buffer_en),
        .addr_to_write_buffer (addr_to_write_buffer),
        .data_to_write_buffer (data_to_write_buffer),
        .wb_full              (wb_full),
        .wb_empty             (wb_empty),
        .wb_count             (wb_count),
        .mem_wr_req           (mem_wr_req),
        .mem_wr_addr          (mem_wr_addr),
        .mem_wr_data          (mem_wr_data),
        .mem_wr_ack           (mem_wr_ack),
        .lookup_addr          (lookup_addr),
        .lookup_hit           (lookup_hit),
        .lookup_data          (lookup_data)
    );

    // One comparison: counts it, reports it on mismatch.
    task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; returns 2 time units after the edge that used them.
    task automatic applyStimulus(input logic en, input logic [AW-1:0] a, input logic [LW-1:0] d,
                                 input logic ack, input logic [AW-1:0] la);
        write_buffer_en      = en;
        addr_to_write_buffer = a;
        data_to_write_buffer = d;
        mem_wr_ack           = ack;
        lookup_addr          = la;
        @(posedge clk);
        #2;
    endtask

    // Youngest buffered copy of a line, or miss with zero data.
    function automatic void modelLookup(input logic [AW-1:0] la, output logic hit, output logic [LW-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (mq[i]) begin
            if (mq[i].a == (la & LINE_MASK)) begin
                hit = 1'b1;
                d   = mq[i].d;
            end
        end
    endfunction

    // Model of one clock edge, from the inputs present before the edge.
    task automatic modelStep();
        ent_t n;
        int   ci;
        int   size_before;
        logic full, pop, alloc;
        n.a   = addr_to_write_buffer & LINE_MASK;
        n.d   = data_to_write_buffer;
        full  = (mq.size() == DEPTH);
        pop   = m_req && mem_wr_ack;
        ci    = -1;
`ifdef WB_COALESCE_EN
        if (write_buffer_en) begin
            foreach (mq[i]) begin
                if (mq[i].a == n.a && !(m_req && i == 0)) ci = i;
            end
        end
`endif
        alloc = write_buffer_en && !full && (ci < 0);
        if (ci >= 0) mq[ci].d = n.d;
        size_before = mq.size();
        if (pop) void'(mq.pop_front());
        if (alloc) mq.push_back(n);
        if (!m_req) begin
            if (size_before != 0) begin
                m_req = 1'b1;
                m_cur = mq[0];
            end
        end else if (pop) begin
            if (mq.size() != 0) m_cur = mq[0];
            else m_req = 1'b0;
        end
    endtask

    // Model update on every edge; cleared whenever reset is asserted.
    initial begin : model_proc
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_req = 1'b0;
                m_cur = '0;
            end else begin
                modelStep();
            end
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    initial begin : compare_proc
        logic          eh;
        logic [LW-1:0] ed;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("count", LW'(wb_count), LW'(mq.size()));
                checkOutput("empty", LW'(wb_empty), LW'(mq.size() == 0));
                checkOutput("full", LW'(wb_full), LW'(mq.size() == DEPTH));
                checkOutput("req", LW'(mem_wr_req), LW'(m_req));
                if (m_req) begin
                    checkOutput("mem_addr", LW'(mem_wr_addr), LW'(m_cur.a));
                    checkOutput("mem_data", mem_wr_data, m_cur.d);
                end
                modelLookup(lookup_addr, eh, ed);
                checkOutput("lk_hit", LW'(lookup_hit), LW'(eh));
                checkOutput("lk_data", lookup_data, ed);
            end
        end
    end

    // Literal reset-value checks.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_full"}, LW'(wb_full), '0);
        checkOutput({tag, "_empty"}, LW'(wb_empty), LW'(1));
        checkOutput({tag, "_count"}, LW'(wb_count), '0);
        checkOutput({tag, "_req"}, LW'(mem_wr_req), '0);
        checkOutput({tag, "_addr"}, LW'(mem_wr_addr), '0);
        checkOutput({tag, "_data"}, mem_wr_data, '0);
        checkOutput({tag, "_hit"}, LW'(lookup_hit), '0);
        checkOutput({tag, "_lkdata"}, lookup_data, '0);
    endtask

    initial begin : main_proc
        logic [AW-1:0] ln [5];
        logic [LW-1:0] dA, dB, dC;
        dA = {4{32'hAAAA_0001}};
        dB = {4{32'hBBBB_0002}};
        dC = {4{32'hCCCC_0003}};

        // Reset state
        lookup_addr = 32'h0000_1000;
        #12;
        checkResetValues("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Single line, ack delayed five cycles
        applyStimulus(1, 32'h0000_1000, dA, 0, 32'h0000_1000);
        checkOutput("t1_count", LW'(wb_count), LW'(1));
        checkOutput("t1_req_early", LW'(mem_wr_req), '0);
        checkOutput("t1_fwd", lookup_data, dA);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, '0, '0, 0, 32'h0000_1000);
            checkOutput("t1_req", LW'(mem_wr_req), LW'(1));
            checkOutput("t1_addr", LW'(mem_wr_addr), LW'(32'h0000_1000));
            checkOutput("t1_data", mem_wr_data, dA);
        end
        applyStimulus(0, '0, '0, 1, '0);
        checkOutput("t1_empty", LW'(wb_empty), LW'(1));
        checkOutput("t1_req_done", LW'(mem_wr_req), '0);

        // Fill to full, drop a fifth push, drain in order without bubbles
        for (int k = 0; k < 5; k++) ln[k] = 32'h0001_0000 + 32'(k) * 32'h100;
        for (int k = 0; k < 5; k++) applyStimulus(1, ln[k] + 32'h4, {4{32'(k + 16)}}, 0, ln[0]);
        checkOutput("t2_full", LW'(wb_full), LW'(1));
        checkOutput("t2_count", LW'(wb_count), LW'(4));
        for (int k = 0; k < 4; k++) begin
            checkOutput("t2_req", LW'(mem_wr_req), LW'(1));
            checkOutput("t2_order", LW'(mem_wr_addr), LW'(ln[k]));
            checkOutput("t2_odata", mem_wr_data, {4{32'(k + 16)}});
            applyStimulus(0, '0, '0, 1, '0);
        end
        checkOutput("t2_empty", LW'(wb_empty), LW'(1));

        // Push and ack together while full, then pointer wrap over three rounds
        for (int k = 0; k < 4; k++) applyStimulus(1, ln[k], {4{32'(k)}}, 0, '0);
        applyStimulus(1, 32'h0000_9000, dB, 1, '0);
        checkOutput("t3_rej_count", LW'(wb_count), LW'(3));
        applyStimulus(1, 32'h0000_9000, dB, 0, '0);
        checkOutput("t3_acc_count", LW'(wb_count), LW'(4));
        for (int k = 0; k < 4; k++) applyStimulus(0, '0, '0, 1, '0);
        checkOutput("t3_empty", LW'(wb_empty), LW'(1));
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++)
                applyStimulus(1, 32'h0010_0000 * 32'(r + 1) + 32'(k) * 32'h100, {4{32'(r * 4 + k)}}, 0, '0);
            checkOutput("t3_wrap_count", LW'(wb_count), LW'(4));
            for (int k = 0; k < 4; k++) begin
                checkOutput("t3_wrap_addr", LW'(mem_wr_addr), LW'(32'h0010_0000 * 32'(r + 1) + 32'(k) * 32'h100));
                applyStimulus(0, '0, '0, 1, '0);
            end
        end

        // Forwarding returns the youngest copy of a line
        applyStimulus(1, 32'h0000_2000, dB, 0, 32'h0000_2008);
        applyStimulus(1, 32'h0000_2000, dC, 0, 32'h0000_2008);
        checkOutput("t4_hit", LW'(lookup_hit), LW'(1));
        checkOutput("t4_data", lookup_data, dC);
        applyStimulus(0, '0, '0, 0, 32'h0000_3000);
        checkOutput("t4_miss", LW'(lookup_hit), '0);
        checkOutput("t4_missdata", lookup_data, '0);
        for (int k = 0; k < 3; k++) applyStimulus(0, '0, '0, 1, '0);
        checkOutput("t4_empty", LW'(wb_empty), LW'(1));

`ifdef WB_COALESCE_EN
        // Merge into a buffered line that is not being drained
        applyStimulus(1, 32'h0000_4000, dA, 0, '0);
        applyStimulus(0, '0, '0, 0, '0);
        applyStimulus(1, 32'h0000_5000, dB, 0, '0);
        checkOutput("t5_count_d", LW'(wb_count), LW'(2));
        applyStimulus(1, 32'h0000_5000, dC, 0, '0);
        checkOutput("t5_count_e", LW'(wb_count), LW'(2));
        applyStimulus(0, '0, '0, 1, '0);
        checkOutput("t5_addr", LW'(mem_wr_addr), LW'(32'h0000_5000));
        checkOutput("t5_data", mem_wr_data, dC);
        applyStimulus(0, '0, '0, 1, '0);
        checkOutput("t5_empty", LW'(wb_empty), LW'(1));
`endif

        // Asynchronous reset during a pending request
        applyStimulus(1, 32'h0000_7000, dA, 0, 32'h0000_7000);
        applyStimulus(0, '0, '0, 0, 32'h0000_7000);
        checkOutput("t6_req_pre", LW'(mem_wr_req), LW'(1));
        rst_n      = 1'b0;
        mem_wr_ack = 1'b1;
        #1;
        checkResetValues("t6");
        @(posedge clk);
        #2;
        mem_wr_ack = 1'b0;
        rst_n      = 1'b1;
        applyStimulus(1, 32'h0000_8000, dB, 0, '0);
        applyStimulus(0, '0, '0, 0, '0);
        checkOutput("t6_req_post", LW'(mem_wr_req), LW'(1));
        checkOutput("t6_addr_post", LW'(mem_wr_addr), LW'(32'h0000_8000));
        applyStimulus(0, '0, '0, 1, '0);
        checkOutput("t6_empty_post", LW'(wb_empty), LW'(1));

        // Randomized traffic over a small line pool
        for (int c = 0; c < 3000; c++) begin
            logic [AW-1:0] pa, la;
            pa = 32'h0002_0000 + (32'($urandom_range(0, 5)) << 8) + 32'($urandom_range(0, 15));
            la = 32'h0002_0000 + (32'($urandom_range(0, 6)) << 8) + 32'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 9) < 6, pa, {$urandom(), $urandom(), $urandom(), $urandom()},
                          $urandom_range(0, 9) < 4, la);
        end
        for (int k = 0; k < DEPTH + 2; k++) applyStimulus(0, '0, '0, 1, '0);
        checkOutput("final_empty", LW'(wb_empty), LW'(1));
        checkOutput("final_req", LW'(mem_wr_req), '0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
